// File: rtl/bus_share_arbiter_if.sv
// Bundles the requester inputs and the shared-bus outputs of the round-robin bus arbiter.
// The master side drives requests and data. The slave side is the arbiter.
interface bus_share_arbiter_if #(
  parameter int SIZE = 16
);
  logic [2:0]      req;
  logic [SIZE-1:0] data0;
  logic [SIZE-1:0] data1;
  logic [SIZE-1:0] data2;
  logic [2:0]      grant;
  logic [1:0]      mux_sel;
  logic            bus_valid;
  logic [SIZE-1:0] bus_data;

  modport master (
    output req, data0, data1, data2,
    input  grant, mux_sel, bus_valid, bus_data
  );

  modport slave (
    input  req, data0, data1, data2,
    output grant, mux_sel, bus_valid, bus_data
  );
endinterface

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter sharing one datapath among three requesters, with forced rotation
// after MAX_HOLD cycles under contention; includes the three-way select mux it steers.
module mux #(
  parameter int SIZE   = 16,
  parameter bit IS3WAY = 1
) (
  input  logic [SIZE-1:0] i_in1,
  input  logic [SIZE-1:0] i_in2,
  input  logic [SIZE-1:0] i_in3,
  input  logic [1:0]      i_sel,
  output logic [SIZE-1:0] o_out
);
  // sel 00 -> in1, 10 -> in2, 01 -> in3; 11 is never driven by the arbiter
  always_comb begin
    o_out = i_in1;
    if (i_sel[1]) begin
      o_out = i_in2;
    end else if (IS3WAY && i_sel[0]) begin
      o_out = i_in3;
    end
  end
endmodule

module bus_share_arbiter #(
  parameter int SIZE     = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  bus_share_arbiter_if.slave bus
);
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  state_t          r_state;
  logic [2:0]      r_grant;
  logic [1:0]      r_mux_sel;
  logic            r_bus_valid;
  logic [3:0]      r_hold_cnt;
  logic [1:0]      r_last_owner;

  logic [3:0]      w_req4;
  logic [3:0]      w_mask;
  logic [1:0]      w_order [3];
  logic            w_found;
  logic [1:0]      w_winner;
  logic            w_owner_req;
  logic            w_take;
  logic            w_drop;
  logic [SIZE-1:0] w_mux_out;

  function automatic logic [1:0] next3(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [1:0] sel_enc(input logic [1:0] idx);
    case (idx)
      2'd1:    return 2'b10;
      2'd2:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Search order chain: last+1, last+2, last (mod 3)
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_order
      if (gi == 0) begin : g_first
        assign w_order[gi] = next3(r_last_owner);
      end else begin : g_rest
        assign w_order[gi] = next3(w_order[gi-1]);
      end
    end
  endgenerate

  // The current owner is masked out; grant is zero while idle so this covers both states
  assign w_req4      = {1'b0, bus.req};
  assign w_mask      = {1'b0, bus.req & ~r_grant};
  assign w_owner_req = w_req4[r_last_owner];

  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (w_mask[w_order[i]]) begin
        w_found  = 1'b1;
        w_winner = w_order[i];
      end
    end
  end

  assign w_take = w_found &&
                  ((r_state == S_IDLE) || !w_owner_req || (r_hold_cnt == HOLD_LAST));
  assign w_drop = (r_state == S_OWNED) && !w_owner_req && !w_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 3'b000;
      r_mux_sel    <= 2'b00;
      r_bus_valid  <= 1'b0;
      r_hold_cnt   <= 4'd0;
      r_last_owner <= 2'd2;
    end else if (w_take) begin
      r_state      <= S_OWNED;
      r_grant      <= 3'b001 << w_winner;
      r_mux_sel    <= sel_enc(w_winner);
      r_bus_valid  <= 1'b1;
      r_hold_cnt   <= 4'd0;
      r_last_owner <= w_winner;
    end else if (w_drop) begin
      r_state     <= S_IDLE;
      r_grant     <= 3'b000;
      r_mux_sel   <= 2'b00;
      r_bus_valid <= 1'b0;
      r_hold_cnt  <= 4'd0;
    end else if (r_state == S_OWNED && r_hold_cnt < HOLD_LAST) begin
      r_hold_cnt <= r_hold_cnt + 4'd1;
    end
  end

  mux #(
    .SIZE   (SIZE),
    .IS3WAY (1'b1)
  ) u_mux (
    .i_in1 (bus.data0),
    .i_in2 (bus.data1),
    .i_in3 (bus.data2),
    .i_sel (r_mux_sel),
    .o_out (w_mux_out)
  );

  assign bus.grant     = r_grant;
  assign bus.mux_sel   = r_mux_sel;
  assign bus.bus_valid = r_bus_valid;
  assign bus.bus_data  = w_mux_out;
endmodule

// File: tb/tb_bus_share_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=1) against a round-robin
// ownership model, plus directed literal checks on the MAX_HOLD=4 instance.
module tb_bus_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] d0, d1, d2;
  logic        chk_on = 1'b0;
  int          checks = 0;
  int          failures = 0;

  int m_owner [2] = '{-1, -1};
  int m_cnt   [2] = '{0, 0};
  int m_last  [2] = '{2, 2};
  int mh      [2] = '{4, 1};

  bus_share_arbiter_if #(.SIZE(16)) if0 ();
  bus_share_arbiter_if #(.SIZE(16)) if1 ();

  assign if0.req = req;  assign if0.data0 = d0;  assign if0.data1 = d1;  assign if0.data2 = d2;
  assign if1.req = req;  assign if1.data0 = d0;  assign if1.data1 = d1;  assign if1.data2 = d2;

  bus_share_arbiter #(.SIZE(16), .MAX_HOLD(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  bus_share_arbiter #(.SIZE(16), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  function automatic int pick(input logic [2:0] mask, input int last);
    for (int i = 1; i <= 3; i++) begin
      if (mask[(last + i) % 3]) return (last + i) % 3;
    end
    return -1;
  endfunction

  function automatic logic [1:0] exp_sel(input int o);
    if (o == 1) return 2'b10;
    if (o == 2) return 2'b01;
    return 2'b00;
  endfunction

  // Ownership model: a new owner gets cnt=1; rotation allowed once cnt reaches MAX_HOLD
  task automatic model_step();
    int w;
    logic [2:0] others;
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        m_owner[n] = -1; m_cnt[n] = 0; m_last[n] = 2;
      end else if (m_owner[n] < 0) begin
        w = pick(req, m_last[n]);
        if (w >= 0) begin m_owner[n] = w; m_cnt[n] = 1; m_last[n] = w; end
      end else begin
        others = req & ~(3'b001 << m_owner[n]);
        if (!req[m_owner[n]]) begin
          w = pick(others, m_last[n]);
          if (w >= 0) begin m_owner[n] = w; m_cnt[n] = 1; m_last[n] = w; end
          else m_owner[n] = -1;
        end else if (m_cnt[n] >= mh[n] && others != 3'b000) begin
          w = pick(others, m_last[n]);
          m_owner[n] = w; m_cnt[n] = 1; m_last[n] = w;
        end else if (m_cnt[n] < 1000) begin
          m_cnt[n] = m_cnt[n] + 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp(input int n, input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, n, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int n, input logic [2:0] g, input logic [1:0] s,
                          input logic v, input logic [15:0] d);
    int o;
    logic [15:0] ed;
    o  = m_owner[n];
    ed = (o == 1) ? d1 : (o == 2) ? d2 : d0;
    cmp(n, "grant", {13'd0, g}, (o < 0) ? 16'd0 : (16'd1 << o));
    cmp(n, "mux_sel", {14'd0, s}, {14'd0, exp_sel(o)});
    cmp(n, "bus_valid", {15'd0, v}, {15'd0, (o >= 0)});
    cmp(n, "bus_data", d, ed);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst(0, if0.grant, if0.mux_sel, if0.bus_valid, if0.bus_data);
      cmp_inst(1, if1.grant, if1.mux_sel, if1.bus_valid, if1.bus_data);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
    else $display("ok %s grant=%b sel=%b valid=%b data=%h", name, if0.grant, if0.mux_sel,
                  if0.bus_valid, if0.bus_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] eg;
    rst = 1'b1; req = 3'b000; d0 = '0; d1 = '0; d2 = '0;
    tick(); tick();
    chk_on = 1'b1;
    chk("reset_grant", {13'd0, if0.grant}, 16'd0);
    chk("reset_sel", {14'd0, if0.mux_sel}, 16'd0);
    chk("reset_valid", {15'd0, if0.bus_valid}, 16'd0);

    // single requester, one-cycle latency
    rst = 1'b0; req = 3'b001; d0 = 16'h000F;
    tick();
    chk("t1_grant", {13'd0, if0.grant}, 16'h0001);
    chk("t1_sel", {14'd0, if0.mux_sel}, 16'd0);
    chk("t1_valid", {15'd0, if0.bus_valid}, 16'd1);
    chk("t1_data", if0.bus_data, 16'h000F);

    // full contention rotates every 4 cycles
    req = 3'b000; do_reset();
    req = 3'b111; d1 = 16'h00F1; d2 = 16'h0F02;
    for (int c = 0; c < 13; c++) begin
      tick();
      eg = (c < 4) ? 3'b001 : (c < 8) ? 3'b010 : (c < 12) ? 3'b100 : 3'b001;
      chk($sformatf("t2_grant_c%0d", c), {13'd0, if0.grant}, {13'd0, eg});
      if (c == 4) begin
        chk("t2_sel1", {14'd0, if0.mux_sel}, 16'h0002);
        chk("t2_data1", if0.bus_data, 16'h00F1);
      end
      if (c == 8) begin
        chk("t2_sel2", {14'd0, if0.mux_sel}, 16'h0001);
        chk("t2_data2", if0.bus_data, 16'h0F02);
      end
    end

    // lone requester keeps the bus
    req = 3'b000; do_reset();
    req = 3'b100;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t3_grant_c%0d", c), {13'd0, if0.grant}, 16'h0004);
    end

    // owner drop hands over with no idle bubble
    do_reset();
    req = 3'b001; tick(); chk("t4_first", {13'd0, if0.grant}, 16'h0001);
    req = 3'b011; tick(); chk("t4_hold", {13'd0, if0.grant}, 16'h0001);
    req = 3'b010; tick(); chk("t4_handover", {13'd0, if0.grant}, 16'h0002);
    chk("t4_valid", {15'd0, if0.bus_valid}, 16'd1);

    // round-robin continues from last owner across idle
    do_reset();
    req = 3'b010; tick(); chk("t5_g1", {13'd0, if0.grant}, 16'h0002);
    req = 3'b000; tick(); chk("t5_idle", {13'd0, if0.grant}, 16'h0000);
    req = 3'b101; tick(); chk("t5_rr", {13'd0, if0.grant}, 16'h0004);

    // reset mid-grant
    do_reset();
    req = 3'b010; tick(); chk("t6_g", {13'd0, if0.grant}, 16'h0002);
    rst = 1'b1; tick();
    chk("t6_rst_grant", {13'd0, if0.grant}, 16'h0000);
    chk("t6_rst_sel", {14'd0, if0.mux_sel}, 16'h0000);
    chk("t6_rst_valid", {15'd0, if0.bus_valid}, 16'h0000);
    rst = 1'b0; tick(); chk("t6_regrant", {13'd0, if0.grant}, 16'h0002);

    // randomized traffic, checked every cycle by the model compare
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
